// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - instruction fetch, local JUMP/CALL/RET/UNL resolution and in-order datapath issue
// Optional feature macro: PROGRAM_SEQUENCER_PERF_EN (retired-instruction and stall counters).
module program_sequencer #(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  output logic            imem_req_o,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [15:0]     imem_data_i,
  output logic            issue_valid_o,
  output logic [15:0]     issue_instr_o,
  input  logic            issue_ready_i,
  output logic            cond_req_o,
  output logic [3:0]      cond_reg_o,
  input  logic            cond_ack_i,
  input  logic            cond_zero_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [1:0]      fault_code_o,
`ifdef PROGRAM_SEQUENCER_PERF_EN
  output logic [31:0]     perf_retired_o,
  output logic [31:0]     perf_stall_o,
`endif
  output logic [PC_W-1:0] pc_o
);

  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SPW:0] SP_FULL = (SPW+1)'(STACK_DEPTH);

  localparam logic [3:0] OP_UNL  = 4'd1;
  localparam logic [3:0] OP_JUMP = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_ISSUE, S_COND, S_DONE, S_FAULT
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [SPW:0]    sp;
  logic [15:0]     ir;
  logic [1:0]      fault_code;
  logic [PC_W-1:0] stack [STACK_DEPTH];

  logic [3:0]      opcode;
  logic [PC_W-1:0] target, pc_inc, pc_rel;
  logic [SPW:0]    sp_dec;
  logic            stack_full, stack_empty, push;

  assign opcode      = ir[15:12];
  assign target      = ir[PC_W-1:0];
  assign pc_inc      = pc + 1'b1;
  // UNL offset is relative to the UNL's own address, not pc+1
  assign pc_rel      = pc + {{(PC_W-8){ir[7]}}, ir[7:0]};
  assign sp_dec      = sp - 1'b1;
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign push        = (state == S_EXEC) && (opcode == OP_CALL) && !stack_full;

  assign imem_addr_o   = pc;
  assign pc_o          = pc;
  assign issue_instr_o = ir;
  assign cond_reg_o    = ir[11:8];
  assign fault_code_o  = fault_code;

  always_ff @(posedge clk) begin
    if (push) stack[sp[SPW-1:0]] <= pc_inc;
  end

  // Each branch sets the flag outputs for the state being entered next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= '0;
      sp            <= '0;
      ir            <= '0;
      fault_code    <= 2'd0;
      imem_req_o    <= 1'b0;
      issue_valid_o <= 1'b0;
      cond_req_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      fault_o       <= 1'b0;
    end else begin
      imem_req_o    <= 1'b0;
      issue_valid_o <= 1'b0;
      cond_req_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      fault_o       <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            pc         <= '0;
            sp         <= '0;
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
            busy_o     <= 1'b1;
          end else begin
            done_o <= (state == S_DONE);
          end
        end
        S_FETCH: begin
          busy_o <= 1'b1;
          if (imem_ack_i) begin
            ir    <= imem_data_i;
            state <= S_EXEC;
          end else begin
            imem_req_o <= 1'b1;
          end
        end
        S_EXEC: begin
          busy_o <= 1'b1;
          case (opcode)
            OP_JUMP: begin
              pc         <= target;
              state      <= S_FETCH;
              imem_req_o <= 1'b1;
            end
            OP_CALL: begin
              if (stack_full) begin
                state      <= S_FAULT;
                fault_code <= 2'd1;
                fault_o    <= 1'b1;
                busy_o     <= 1'b0;
              end else begin
                sp         <= sp + 1'b1;
                pc         <= target;
                state      <= S_FETCH;
                imem_req_o <= 1'b1;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state      <= S_FAULT;
                fault_code <= 2'd2;
                fault_o    <= 1'b1;
                busy_o     <= 1'b0;
              end else begin
                sp         <= sp_dec;
                pc         <= stack[sp_dec[SPW-1:0]];
                state      <= S_FETCH;
                imem_req_o <= 1'b1;
              end
            end
            OP_UNL: begin
              state      <= S_COND;
              cond_req_o <= 1'b1;
            end
            OP_HALT: begin
              state  <= S_DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end
            default: begin
              state         <= S_ISSUE;
              issue_valid_o <= 1'b1;
            end
          endcase
        end
        S_ISSUE: begin
          busy_o <= 1'b1;
          if (issue_ready_i) begin
            pc         <= pc_inc;
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
          end else begin
            issue_valid_o <= 1'b1;
          end
        end
        S_COND: begin
          busy_o <= 1'b1;
          if (cond_ack_i) begin
            pc         <= cond_zero_i ? pc_rel : pc_inc;
            state      <= S_FETCH;
            imem_req_o <= 1'b1;
          end else begin
            cond_req_o <= 1'b1;
          end
        end
        S_FAULT: begin
          fault_o <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PROGRAM_SEQUENCER_PERF_EN
  logic retire, stall, restart;

  assign restart = ((state == S_IDLE) || (state == S_DONE)) && start_i;
  assign retire  = ((state == S_ISSUE) && issue_ready_i) ||
                   ((state == S_COND) && cond_ack_i) ||
                   ((state == S_EXEC) && ((opcode == OP_JUMP) ||
                                          ((opcode == OP_CALL) && !stack_full) ||
                                          ((opcode == OP_RET) && !stack_empty)));
  assign stall   = ((state == S_FETCH) && !imem_ack_i) ||
                   ((state == S_ISSUE) && !issue_ready_i) ||
                   ((state == S_COND) && !cond_ack_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_o <= '0;
      perf_stall_o   <= '0;
    end else if (restart) begin
      perf_retired_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (retire && !(&perf_retired_o)) perf_retired_o <= perf_retired_o + 1'b1;
      if (stall && !(&perf_stall_o))    perf_stall_o   <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - scoreboard bench for program_sequencer (default build)
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [11:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [15:0] imem_data_i = 16'h0;
  logic        issue_valid_o;
  logic [15:0] issue_instr_o;
  logic        issue_ready_i = 1'b0;
  logic        cond_req_o;
  logic [3:0]  cond_reg_o;
  logic        cond_ack_i = 1'b0;
  logic        cond_zero_i = 1'b0;
  logic        busy_o, done_o, fault_o;
  logic [1:0]  fault_code_o;
  logic [11:0] pc_o;

  program_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .issue_valid_o(issue_valid_o), .issue_instr_o(issue_instr_o),
    .issue_ready_i(issue_ready_i),
    .cond_req_o(cond_req_o), .cond_reg_o(cond_reg_o),
    .cond_ack_i(cond_ack_i), .cond_zero_i(cond_zero_i),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [0:4095];
  logic [11:0] exp_fetch [$];
  logic [15:0] exp_issue [$];
  logic [3:0]  exp_cond_reg = 4'd0;
  logic        cond_zero_val = 1'b0;
  logic        ack_en = 1'b1;
  logic        ack_rand = 1'b0;
  int          ready_delay = 0;
  int          valid_cycles = 0;
  int          fetch_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory, datapath and condition responders; they also pop the scoreboard.
  always @(negedge clk) begin
    imem_ack_i    = 1'b0;
    issue_ready_i = 1'b0;
    cond_ack_i    = 1'b0;
    if (imem_req_o && ack_en && (!ack_rand || ($urandom_range(0, 1) == 1))) begin
      imem_ack_i  = 1'b1;
      imem_data_i = mem[imem_addr_o];
      fetch_count++;
      if (exp_fetch.size() == 0) check("fetch_q_nonempty", exp_fetch.size(), 1);
      else check("fetch_addr", imem_addr_o, exp_fetch.pop_front());
    end
    if (issue_valid_o) begin
      if (valid_cycles < ready_delay) begin
        valid_cycles++;
        if (exp_issue.size() != 0) check("issue_stable", issue_instr_o, exp_issue[0]);
      end else begin
        issue_ready_i = 1'b1;
        valid_cycles  = 0;
        if (exp_issue.size() == 0) check("issue_q_nonempty", exp_issue.size(), 1);
        else check("issue_instr", issue_instr_o, exp_issue.pop_front());
      end
    end
    if (cond_req_o) begin
      cond_ack_i  = 1'b1;
      cond_zero_i = cond_zero_val;
      check("cond_reg", cond_reg_o, exp_cond_reg);
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic run_prog(input int max_cycles);
    pulse_start();
    for (int i = 0; i < max_cycles; i++) begin
      if (done_o || fault_o) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_fetch_left"}, exp_fetch.size(), 0);
    check({tag, "_issue_left"}, exp_issue.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  initial begin
    clear_mem();
    #12;
    check("rst_req", imem_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pc", pc_o, 0);
    rst_n = 1'b1;

    // Straight-line issue with delayed ready
    mem[0] = 16'h2123;
    exp_fetch.push_back(12'h000); exp_fetch.push_back(12'h001);
    exp_issue.push_back(16'h2123);
    ready_delay = 3;
    run_prog(200);
    check("t1_done", done_o, 1);
    check("t1_pc", pc_o, 1);
    check("t1_busy", busy_o, 0);
    check_queues("t1");
    ready_delay = 0;

    // CALL/RET with random fetch latency
    clear_mem();
    mem[0] = 16'hD010; mem[12'h010] = 16'hE000; mem[1] = 16'hF000;
    exp_fetch.push_back(12'h000); exp_fetch.push_back(12'h010); exp_fetch.push_back(12'h001);
    ack_rand = 1'b1;
    run_prog(400);
    ack_rand = 1'b0;
    check("t2_done", done_o, 1);
    check("t2_pc", pc_o, 1);
    check_queues("t2");

    // UNL taken and not taken
    for (int z = 1; z >= 0; z--) begin
      clear_mem();
      mem[0] = 16'hC005; mem[5] = 16'h13FE;
      cond_zero_val = z[0];
      exp_cond_reg  = 4'd3;
      exp_fetch.push_back(12'h000); exp_fetch.push_back(12'h005);
      exp_fetch.push_back(z[0] ? 12'h003 : 12'h006);
      run_prog(200);
      check("t3_done", done_o, 1);
      check("t3_pc", pc_o, z[0] ? 32'h3 : 32'h6);
      check_queues("t3");
    end

    // PC wrap past 0xFFF
    clear_mem();
    mem[0] = 16'hCFFF; mem[12'hFFF] = 16'h2123;
    exp_fetch.push_back(12'h000); exp_fetch.push_back(12'hFFF); exp_fetch.push_back(12'h000);
    exp_issue.push_back(16'h2123);
    fetch_count = 0;
    pulse_start();
    for (int i = 0; i < 100 && fetch_count == 0; i++) @(posedge clk);
    mem[0] = 16'hF000;
    for (int i = 0; i < 200; i++) begin
      if (done_o || fault_o) break;
      @(posedge clk); #1;
    end
    check("t4_done", done_o, 1);
    check("t4_pc", pc_o, 0);
    check_queues("t4");

    // Stack overflow on the 33rd self-call
    clear_mem();
    mem[0] = 16'hD000;
    for (int i = 0; i < 33; i++) exp_fetch.push_back(12'h000);
    run_prog(2000);
    check("t5_fault", fault_o, 1);
    check("t5_code", fault_code_o, 1);
    check_queues("t5");
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check("t5_fault_hold", fault_o, 1);
    check("t5_no_fetch", imem_req_o, 0);
    check("t5_not_busy", busy_o, 0);
    check("t5_code_hold", fault_code_o, 1);

    // Stack underflow
    do_reset();
    clear_mem();
    mem[0] = 16'hE000;
    exp_fetch.push_back(12'h000);
    run_prog(200);
    check("t6_fault", fault_o, 1);
    check("t6_code", fault_code_o, 2);
    check_queues("t6");

    // Asynchronous reset while a fetch is outstanding
    do_reset();
    check("t7_code_clr", fault_code_o, 0);
    clear_mem();
    mem[0] = 16'h2123;
    ack_en = 1'b0;
    mem[0] = 16'hD123;
    pulse_start();
    for (int i = 0; i < 20 && !imem_req_o; i++) @(posedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("t7_req", imem_req_o, 0);
    check("t7_busy", busy_o, 0);
    check("t7_pc", pc_o, 0);
    check("t7_valid", issue_valid_o, 0);
    check("t7_fault", fault_o, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    ack_en = 1'b1;
    mem[0] = 16'hF000;
    exp_fetch.push_back(12'h000);
    run_prog(200);
    check("t7_done", done_o, 1);
    check("t7_pc_end", pc_o, 0);
    check_queues("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Control-flow unit of the cellular automaton processor. Fetches 16-bit instructions from instruction memory and resolves JUMP, CALL, RET and UNL locally using a return-address stack.
- Dispatches all other opcodes (LI, ADD..FMUL) in order to the cell-array datapath over a valid/ready handshake.
- Obtains UNL conditions from the datapath through a request/ack query.

Parameters:
- PC_W, 12, program counter and jump-address width; PC arithmetic wraps modulo 2**PC_W.
- STACK_DEPTH, 32, return-stack entries; must be a power of two ≤ 32.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse: begin execution at PC 0 (honoured only in IDLE/DONE)
- imem_req_o  in/out: out  1  fetch request, held until ack
- imem_addr_o  out  PC_W  fetch address, stable while imem_req_o high
- imem_ack_i  in  1  fetch complete; imem_data_i valid this cycle
- imem_data_i  in  16  instruction word
- issue_valid_o  out  1  datapath instruction valid
- issue_instr_o  out  16  instruction to datapath, stable while valid and not ready
- issue_ready_i  in  1  datapath accepts instruction
- cond_req_o  out  1  condition query, held until ack
- cond_reg_o  out  4  condition register index (instr[11:8])
- cond_ack_i  in  1  condition valid this cycle; it reflects all previously issued instructions
- cond_zero_i  in  1  1 when the queried register is zero in all cells
- busy_o  out  1  high in FETCH/EXEC/ISSUE/COND
- done_o  out  1  high in DONE
- fault_o  out  1  high in FAULT
- fault_code_o  out  2  0 none, 1 stack overflow, 2 stack underflow
- pc_o  out  PC_W  current PC

Behaviour:
- Reset: async assert → state IDLE, pc=0, sp=0. All outputs 0; stack contents don't-care.
- IDLE:
  - start_i → pc=0, sp=0, FETCH.
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - On imem_ack_i: latch imem_data_i into ir, go EXEC.
  - Minimum fetch-to-EXEC is 1 cycle with same-cycle ack.
- EXEC: one cycle; decode ir[15:12].
  - LI, ADD..FMUL (0, 2–11): go ISSUE.
  - JUMP (12): pc ← ir[11:0], FETCH.
  - CALL (13):
    - If sp == STACK_DEPTH: FAULT with code 1, stack untouched.
    - Else stack[sp] ← pc+1, sp++, pc ← ir[11:0], FETCH.
  - RET (14):
    - If sp == 0: FAULT with code 2.
    - Else pc ← stack[sp-1], sp--, FETCH.
  - UNL (1): go COND.
  - Opcode 15 (HALT): go DONE.
- ISSUE: issue_valid_o=1, issue_instr_o=ir.
  - On issue_ready_i: pc ← pc+1, FETCH.
  - Valid never drops before the handshake.
- COND: cond_req_o=1, cond_reg_o=ir[11:8].
  - On cond_ack_i with cond_zero_i=1: pc ← pc + sext(ir[7:0]) (relative to the UNL's own address).
  - On cond_ack_i with cond_zero_i=0: pc ← pc+1.
  - Either way, go FETCH.
- DONE: done_o=1. start_i restarts as from IDLE.
- FAULT: fault_o=1, fault_code_o held. Exit only by reset; start_i is ignored.
- start_i is ignored in all busy states.
- PC wrap: pc+1 at 0xFFF → 0x000. Relative targets wrap modulo 4096.
- An ack or ready that arrives in a state not requesting it is ignored.
- Reset mid-handshake: outputs drop asynchronously; no partial stack update is retained.

Optional Feature:
- Macro: PROGRAM_SEQUENCER_PERF_EN.
- Defined: adds outputs perf_retired_o (32 bits) and perf_stall_o (32 bits).
  - perf_retired_o increments once per completed ISSUE handshake and once per resolved JUMP/CALL/RET/UNL.
  - perf_stall_o increments on every cycle in FETCH without ack, ISSUE without ready, or COND without ack.
  - Both counters clear on reset and on an accepted start_i, and saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Straight-line issue: mem[0]=0x2123 (ADD), mem[1]=0xF000; start, issue_ready_i delayed 3 cycles.
  - Expect exactly one issue of 0x2123, held stable for 3 cycles, then done_o=1 with pc_o=1.
- CALL/RET: mem[0]=0xD010, mem[0x10]=0xE000, mem[1]=0xF000.
  - Expect fetch addresses 0, 0x10, 1; sp back to 0; done_o=1.
- UNL: mem[5]=0x13FE (offset −2), run twice.
  - With cond_zero_i=1: cond_reg_o=3 and next fetch address is 3.
  - With cond_zero_i=0: next fetch address is 6.
- Overflow: STACK_DEPTH=32, mem[0]=0xD000 (self-call).
  - After 32 pushes the 33rd CALL sets fault_o=1, fault_code_o=1; further start_i is ignored.
- Underflow and wrap:
  - mem[0]=0xE000 → fault_code_o=2.
  - Separately, JUMP to 0xFFF holding an ADD → next fetch address is 0x000.
- Async reset while imem_req_o is high and ack is pending → all outputs 0 immediately; a later start_i fetches from 0.
